fb_line_fetcher: RTL and testbench



---
 rtl/fb_line_fetcher_if.sv | 23 ++
 rtl/fb_line_fetcher.sv | 250 +++++++++++++++++++++++++
 tb/tb_fb_line_fetcher.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_line_fetcher_if.sv
// Burst-FIFO and pixel-stream bundle for fb_line_fetcher.
// master: the fetcher side; slave: SDRAM controller FIFOs plus the pixel sink.
interface fb_line_fetcher_if;
   logic [31:0]  burst_cmd_d_o;
   logic         burst_cmd_enq_o;
   logic         burst_cmd_full_i;
   logic [127:0] burst_q_i;
   logic         burst_deq_o;
   logic         burst_empty_i;
   logic [15:0]  pixel_o;
   logic         pixel_valid_o;
   logic         pixel_ready_i;

   modport master (
      output burst_cmd_d_o, burst_cmd_enq_o, burst_deq_o, pixel_o, pixel_valid_o,
      input  burst_cmd_full_i, burst_q_i, burst_empty_i, pixel_ready_i
   );

   modport slave (
      input  burst_cmd_d_o, burst_cmd_enq_o, burst_deq_o, pixel_o, pixel_valid_o,
      output burst_cmd_full_i, burst_q_i, burst_empty_i, pixel_ready_i
   );
endinterface

// File: rtl/fb_line_fetcher.sv
// Scanline fetcher: issues 8-word burst reads and unpacks 128-bit bursts into 16-bit pixels.
// Optional underrun statistics counter enabled by FB_FETCH_STATS_EN.
module fb_line_fetcher #(
   parameter int FB_WIDTH        = 640,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STAT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [23:0]           line_addr_i,
   input  logic                  abort_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [STAT_WIDTH-1:0] stat_underrun_o,
   fb_line_fetcher_if.master     bus
);

   localparam int NBURST = FB_WIDTH / 8;
   localparam int CNT_W  = $clog2(NBURST + 1);

   typedef enum logic [2:0] {
      C_IDLE = 3'd0,
      C_WAIT = 3'd1,
      C_DEQ  = 3'd2,
      C_LOAD = 3'd3,
      C_EMIT = 3'd4
   } c_state_t;

   c_state_t     state_q, state_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         abort_q, abort_d;
   logic [23:0]  cmd_addr_q, cmd_addr_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] consumed_q, consumed_d;
   logic [3:0]   outstanding_q, outstanding_d;
   logic         enq_q, enq_d;
   logic [31:0]  cmd_q, cmd_d;
   logic         deq_q, deq_d;
   logic [127:0] shreg_q, shreg_d;
   logic [2:0]   idx_q, idx_d;
   logic         valid_q, valid_d;

   logic         issue_ok_s;
   logic         aborting_s;
   logic         out_inc_s;
   logic         out_dec_s;

   // Issue engine, consume FSM and outstanding-burst bookkeeping.
   always_comb begin
      state_d       = state_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      abort_d       = abort_q;
      cmd_addr_d    = cmd_addr_q;
      issued_d      = issued_q;
      consumed_d    = consumed_q;
      outstanding_d = outstanding_q;
      enq_d         = 1'b0;
      cmd_d         = cmd_q;
      deq_d         = 1'b0;
      shreg_d       = shreg_q;
      idx_d         = idx_q;
      valid_d       = valid_q;
      out_inc_s     = 1'b0;
      out_dec_s     = 1'b0;

      aborting_s = abort_q || (abort_i && busy_q);
      issue_ok_s = busy_q && !aborting_s
                   && (issued_q < CNT_W'(NBURST))
                   && !bus.burst_cmd_full_i
                   && (outstanding_q < 4'(MAX_OUTSTANDING));

      if (abort_i && busy_q) begin
         abort_d = 1'b1;
      end else begin
         abort_d = abort_q;
      end

      if (issue_ok_s) begin
         enq_d      = 1'b1;
         cmd_d      = {8'h00, cmd_addr_q};
         cmd_addr_d = cmd_addr_q + 24'd8;
         issued_d   = issued_q + CNT_W'(1);
         out_inc_s  = 1'b1;
      end else begin
         enq_d = 1'b0;
      end

      case (state_q)
         C_IDLE: begin
            if (start_i) begin
               cmd_addr_d = line_addr_i;
               issued_d   = {CNT_W{1'b0}};
               consumed_d = {CNT_W{1'b0}};
               busy_d     = 1'b1;
               abort_d    = 1'b0;
               valid_d    = 1'b0;
               state_d    = C_WAIT;
            end else begin
               state_d = C_IDLE;
            end
         end
         C_WAIT: begin
            // While aborting, remaining bursts are drained here until none are outstanding.
            if (aborting_s && (outstanding_q == 4'd0)) begin
               busy_d  = 1'b0;
               abort_d = 1'b0;
               state_d = C_IDLE;
            end else if (!bus.burst_empty_i) begin
               deq_d   = 1'b1;
               state_d = C_DEQ;
            end else begin
               state_d = C_WAIT;
            end
         end
         C_DEQ: begin
            state_d = C_LOAD;
         end
         C_LOAD: begin
            shreg_d    = bus.burst_q_i;
            out_dec_s  = 1'b1;
            consumed_d = consumed_q + CNT_W'(1);
            idx_d      = 3'd0;
            if (aborting_s) begin
               valid_d = 1'b0;
               state_d = C_WAIT;
            end else begin
               valid_d = 1'b1;
               state_d = C_EMIT;
            end
         end
         C_EMIT: begin
            if (aborting_s) begin
               valid_d = 1'b0;
               state_d = C_WAIT;
            end else if (bus.pixel_ready_i) begin
               shreg_d = {shreg_q[111:0], 16'h0000};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  valid_d = 1'b0;
                  if (consumed_q == CNT_W'(NBURST)) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = C_IDLE;
                  end else begin
                     state_d = C_WAIT;
                  end
               end else begin
                  state_d = C_EMIT;
               end
            end else begin
               state_d = C_EMIT;
            end
         end
         default: begin
            state_d = C_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
         end
      endcase

      // Issue and load in the same cycle leave the count unchanged.
      case ({out_inc_s, out_dec_s})
         2'b10:   outstanding_d = outstanding_q + 4'd1;
         2'b01:   outstanding_d = outstanding_q - 4'd1;
         default: outstanding_d = outstanding_q;
      endcase

      if (start_i && !busy_q) begin
         outstanding_d = 4'd0;
      end else begin
         outstanding_d = outstanding_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q       <= C_IDLE;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         abort_q       <= 1'b0;
         cmd_addr_q    <= 24'd0;
         issued_q      <= {CNT_W{1'b0}};
         consumed_q    <= {CNT_W{1'b0}};
         outstanding_q <= 4'd0;
         enq_q         <= 1'b0;
         cmd_q         <= 32'd0;
         deq_q         <= 1'b0;
         shreg_q       <= 128'd0;
         idx_q         <= 3'd0;
         valid_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         abort_q       <= abort_d;
         cmd_addr_q    <= cmd_addr_d;
         issued_q      <= issued_d;
         consumed_q    <= consumed_d;
         outstanding_q <= outstanding_d;
         enq_q         <= enq_d;
         cmd_q         <= cmd_d;
         deq_q         <= deq_d;
         shreg_q       <= shreg_d;
         idx_q         <= idx_d;
         valid_q       <= valid_d;
      end
   end

   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign bus.burst_cmd_enq_o = enq_q;
   assign bus.burst_cmd_d_o   = cmd_q;
   assign bus.burst_deq_o     = deq_q;
   assign bus.pixel_o         = shreg_q[127:112];
   assign bus.pixel_valid_o   = valid_q;

`ifdef FB_FETCH_STATS_EN
   logic [STAT_WIDTH-1:0] stat_q, stat_d;

   // Saturating count of cycles where the sink was ready but no pixel was offered.
   always_comb begin
      stat_d = stat_q;
      if (start_i && !busy_q) begin
         stat_d = {STAT_WIDTH{1'b0}};
      end else if (busy_q && bus.pixel_ready_i && !valid_q && (stat_q != {STAT_WIDTH{1'b1}})) begin
         stat_d = stat_q + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         stat_d = stat_q;
      end
   end

   // Underrun counter register.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         stat_q <= {STAT_WIDTH{1'b0}};
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_underrun_o = stat_q;
`else
   assign stat_underrun_o = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Directed bench for fb_line_fetcher with a behavioural model of the SDRAM burst FIFOs.
module tb_fb_line_fetcher;
   localparam int FBW  = 32;
   localparam int MAXO = 2;
   localparam int SW   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [23:0]   line_addr;
   logic          busy;
   logic          done;
   logic [SW-1:0] stat;

   fb_line_fetcher_if bus();

   fb_line_fetcher #(.FB_WIDTH(FBW), .MAX_OUTSTANDING(MAXO), .STAT_WIDTH(SW)) dut (
      .clk             (clk),
      .rst_i           (rst),
      .start_i         (start),
      .line_addr_i     (line_addr),
      .abort_i         (abort),
      .busy_o          (busy),
      .done_o          (done),
      .stat_underrun_o (stat),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int  cyc = 0;
   int  delay = 3;
   bit  hold = 1'b0;
   logic [23:0] pend_addr[$];
   int          pend_t[$];
   logic [31:0] enq_log[$];
   int          enq_cyc[$];
   int          deq_cyc[$];
   logic [15:0] pix_log[$];
   int  acc_cyc = -1;
   int  done_cyc = -1;
   int  done_cnt = 0;
   int  first_valid_cyc = -1;
   int  enq_in_full = 0;
   int  stall_cnt = 0;
   int  stall_viol = 0;
   int  deq_underflow = 0;
   int  start_cyc = 0;
   bit  prev_valid = 1'b0;
   bit  prev_ready = 1'b0;
   logic [15:0] prev_pix = 16'h0000;

   // Burst at word address a holds pixels a, a+1 .. a+7 (low 16 bits), lowest address in the top lane.
   function automatic logic [127:0] make_burst(input logic [23:0] a);
      logic [127:0] b;
      b = 128'd0;
      for (int k = 0; k < 8; k++) begin
         b[127-16*k -: 16] = a[15:0] + 16'(k);
      end
      return b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pend_addr.delete();
         pend_t.delete();
         bus.burst_q_i <= 128'd0;
         prev_valid = 1'b0;
      end else begin
         if (bus.burst_cmd_enq_o) begin
            enq_log.push_back(bus.burst_cmd_d_o);
            enq_cyc.push_back(cyc);
            pend_addr.push_back(bus.burst_cmd_d_o[23:0]);
            pend_t.push_back(cyc + delay);
            if (bus.burst_cmd_full_i) enq_in_full++;
         end
         if (bus.burst_deq_o) begin
            deq_cyc.push_back(cyc);
            if (pend_addr.size() > 0) begin
               bus.burst_q_i <= make_burst(pend_addr.pop_front());
               pend_t.delete(0);
            end else begin
               deq_underflow++;
            end
         end
         if (bus.pixel_valid_o && bus.pixel_ready_i) begin
            pix_log.push_back(bus.pixel_o);
            acc_cyc = cyc;
         end
         if (bus.pixel_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_valid && !prev_ready) begin
            stall_cnt++;
            if (!bus.pixel_valid_o || bus.pixel_o !== prev_pix) stall_viol++;
         end
         prev_valid = bus.pixel_valid_o;
         prev_ready = bus.pixel_ready_i;
         prev_pix   = bus.pixel_o;
      end
      cyc = cyc + 1;
      bus.burst_empty_i <= !(pend_t.size() > 0 && pend_t[0] <= cyc && !hold);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      enq_log.delete();
      enq_cyc.delete();
      deq_cyc.delete();
      pix_log.delete();
      first_valid_cyc = -1;
      enq_in_full = 0;
      stall_cnt = 0;
      stall_viol = 0;
   endtask

   task automatic do_start(input logic [23:0] a);
      clear_logs();
      line_addr = a;
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int maxc, input bit toggle);
      int n;
      int d0;
      n = 0;
      d0 = done_cnt;
      while (done_cnt == d0 && n < maxc) begin
         if (toggle) bus.pixel_ready_i = ~bus.pixel_ready_i;
         tick();
         n++;
      end
      bus.pixel_ready_i = 1'b1;
      chk({tag, "_done_seen"}, done_cnt - d0, 1);
      chk({tag, "_busy_low"}, busy, 1'b0);
   endtask

   task automatic check_line(input string tag, input logic [23:0] a);
      int bad_pix;
      int bad_cmd;
      bad_pix = 0;
      bad_cmd = 0;
      for (int i = 0; i < pix_log.size(); i++) begin
         if (pix_log[i] !== a[15:0] + 16'(i)) bad_pix++;
      end
      for (int i = 0; i < enq_log.size(); i++) begin
         if (enq_log[i] !== {8'h00, a + 24'(8 * i)}) bad_cmd++;
      end
      chk({tag, "_pix_count"}, pix_log.size(), FBW);
      chk({tag, "_pix_order"}, bad_pix, 0);
      chk({tag, "_cmd_count"}, enq_log.size(), FBW / 8);
      chk({tag, "_cmd_addr"}, bad_cmd, 0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_enq"}, bus.burst_cmd_enq_o, 1'b0);
      chk({tag, "_deq"}, bus.burst_deq_o, 1'b0);
      chk({tag, "_valid"}, bus.pixel_valid_o, 1'b0);
      chk({tag, "_pixel"}, bus.pixel_o, 16'h0000);
      chk({tag, "_stat"}, stat, {SW{1'b0}});
   endtask

   initial begin
      int n;
      int n_acc;
      int d_before;
      bit ok;

      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      line_addr = 24'd0;
      bus.burst_cmd_full_i = 1'b0;
      bus.pixel_ready_i = 1'b1;
      repeat (3) tick();
      check_reset("reset");
      rst = 1'b0;
      tick();

      // Basic line: data 3 cycles after each command, sink always ready.
      do_start(24'h000100);
      wait_done("line1", 300, 1'b0);
      check_line("line1", 24'h000100);
      chk("line1_first_valid_latency", first_valid_cyc - start_cyc, 8);
      chk("line1_done_after_last_accept", done_cyc - acc_cyc, 1);
      chk("line1_done_once", done_cnt, 1);

      // Outstanding limit with data withheld.
      hold = 1'b1;
      do_start(24'h000200);
      repeat (20) tick();
      chk("maxout_enq_while_held", enq_log.size(), MAXO);
      chk("maxout_no_deq_while_held", deq_cyc.size(), 0);
      hold = 1'b0;
      n = 0;
      while (enq_log.size() < 3 && n < 50) begin
         tick();
         n++;
      end
      ok = (enq_cyc.size() >= 3) && (deq_cyc.size() >= 1) && (enq_cyc[2] > deq_cyc[0]);
      chk("maxout_third_enq_after_deq", ok, 1'b1);
      wait_done("maxout", 300, 1'b0);
      check_line("maxout", 24'h000200);

      // Back-pressure: ready toggles, first burst carries 0x0001..0x0008.
      do_start(24'h000001);
      wait_done("stall", 400, 1'b1);
      check_line("stall", 24'h000001);
      chk("stall_seen", stall_cnt > 0, 1'b1);
      chk("stall_pixel_stable", stall_viol, 0);

      // Command FIFO full for 5 cycles right after start.
      do_start(24'h000300);
      bus.burst_cmd_full_i = 1'b1;
      repeat (5) tick();
      bus.burst_cmd_full_i = 1'b0;
      wait_done("full", 300, 1'b0);
      chk("full_no_enq_while_full", enq_in_full, 0);
      chk("full_first_enq_after_window", enq_cyc.size() > 0 && enq_cyc[0] > start_cyc + 5, 1'b1);
      check_line("full", 24'h000300);

      // Abort after 3 bursts issued and 1 consumed.
      d_before = done_cnt;
      do_start(24'h000400);
      n = 0;
      while (!(enq_log.size() == 3 && pix_log.size() >= 2) && n < 100) begin
         tick();
         n++;
      end
      chk("abort_reached_point", deq_cyc.size(), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_acc = pix_log.size();
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("abort_busy_low", busy, 1'b0);
      chk("abort_no_pixels_after", pix_log.size(), n_acc);
      chk("abort_drain_deqs", deq_cyc.size(), 3);
      chk("abort_no_more_issue", enq_log.size(), 3);
      chk("abort_no_done", done_cnt, d_before);
      chk("abort_valid_low", bus.pixel_valid_o, 1'b0);
      chk("abort_no_underflow", deq_underflow, 0);
      do_start(24'h000500);
      wait_done("after_abort", 300, 1'b0);
      check_line("after_abort", 24'h000500);

      // Long data latency: underrun statistic, then reset mid-line.
      delay = 8;
      do_start(24'h000600);
      n = 0;
      while (first_valid_cyc < 0 && n < 60) begin
         tick();
         n++;
      end
      chk("stats_first_valid_latency", first_valid_cyc - start_cyc, 13);
`ifdef FB_FETCH_STATS_EN
      chk("stats_underrun", stat, 16'd12);
`else
      chk("stats_underrun_tied", stat, 16'd0);
`endif
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check_reset("midline_reset");
      rst = 1'b0;
      tick();
      chk("post_reset_idle", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
